// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit for jedro_1: owns the PC, issues sequential reads to a
// fixed-latency RAM and buffers returned words in a prefetch FIFO for decode.
module jedro_1_ifu #(
  parameter int unsigned               DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]     BOOT_ADDR   = 32'h0000_0000,
  parameter int unsigned               MEM_LATENCY = 1,
  parameter int unsigned               FIFO_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic                  ram_rsta_o,
  output logic                  ram_en_o,
  output logic [DATA_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  input  logic                  jmp_i,
  input  logic [DATA_WIDTH-1:0] jmp_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_addr_o,
  output logic                  misalign_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + MEM_LATENCY + 1);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("jedro_1_ifu: MEM_LATENCY must be in 1..4");
  end
  if (FIFO_DEPTH < MEM_LATENCY + 2) begin : g_bad_depth
    $error("jedro_1_ifu: FIFO_DEPTH must be at least MEM_LATENCY+2");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_pow2
    $error("jedro_1_ifu: FIFO_DEPTH must be a power of two");
  end
  if (BOOT_ADDR[1:0] != 2'b00) begin : g_bad_boot
    $error("jedro_1_ifu: BOOT_ADDR must be word aligned");
  end

  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [MEM_LATENCY-1:0] stage_vld_q, stage_vld_d;
  logic [DATA_WIDTH-1:0]  stage_addr_q [MEM_LATENCY];
  logic [DATA_WIDTH-1:0]  stage_addr_d [MEM_LATENCY];
  logic [DATA_WIDTH-1:0]  fifo_instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_instr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_addr_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic                   misalign_q, misalign_d;

  logic [CNT_W-1:0]       inflight_cnt;
  logic [CNT_W-1:0]       occupancy;
  logic                   push;
  logic                   pop;

  // Credit counts only registered state, so a same-cycle pop never frees a slot early.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(stage_vld_q[i]);
    end
  end

  assign occupancy     = fifo_cnt_q + inflight_cnt;
  assign ram_en_o      = rstn_i & ~jmp_i & (occupancy < CNT_W'(FIFO_DEPTH));
  assign ram_addr_o    = pc_q;
  assign ram_rsta_o    = ~rstn_i;
  assign instr_valid_o = (fifo_cnt_q != '0);
  assign instr_o       = fifo_instr_q[rd_ptr_q];
  assign instr_addr_o  = fifo_addr_q[rd_ptr_q];
  assign misalign_o    = misalign_q;
  assign push          = stage_vld_q[MEM_LATENCY-1] & ~jmp_i;
  assign pop           = instr_valid_o & instr_ready_i;

  always_comb begin
    pc_d         = pc_q;
    stage_vld_d  = stage_vld_q;
    stage_addr_d = stage_addr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_addr_d  = fifo_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    misalign_d   = 1'b0;

    stage_vld_d[0]  = ram_en_o;
    stage_addr_d[0] = pc_q;
    for (int k = 1; k < MEM_LATENCY; k++) begin
      stage_vld_d[k]  = stage_vld_q[k-1];
      stage_addr_d[k] = stage_addr_q[k-1];
    end
    if (ram_en_o) begin
      pc_d = pc_q + DATA_WIDTH'(4);
    end

    if (push) begin
      fifo_instr_d[wr_ptr_q] = ram_data_i;
      fifo_addr_d[wr_ptr_q]  = stage_addr_q[MEM_LATENCY-1];
      wr_ptr_d               = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

    // A redirect drops everything fetched so far, including a word landing this cycle.
    if (jmp_i) begin
      stage_vld_d = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      fifo_cnt_d  = '0;
      pc_d        = {jmp_addr_i[DATA_WIDTH-1:2], 2'b00};
      misalign_d  = |jmp_addr_i[1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q        <= BOOT_ADDR;
      stage_vld_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stage_addr_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_addr_q[i]  <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      stage_vld_q  <= stage_vld_d;
      stage_addr_q <= stage_addr_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_addr_q  <= fifo_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule
